mrd_fsm: RTL and testbench



---
 rtl/z80_bus_pkg.sv | 19 +
 rtl/mrd_fsm.sv | 64 ++++++
 tb/tb_mrd_fsm.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared bus-cycle definitions for the Z80 bus-interface state machines.
// No logic and no latency: only types and constants.
// No backpressure: every sibling FSM imports these definitions unchanged.
package z80_bus_pkg;

    // Bus-cycle phases shared by the opcode-fetch, memory and I/O FSMs.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4
    } bus_state_e;

    // Active-low strobe levels.
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

endpackage

// File: rtl/mrd_fsm.sv
// Memory-read bus-cycle controller: sequences T1, T2, optional TW and T3, driving MREQ/RD.
// Latency: strobes go low the cycle after MRD_start is sampled high; 3 clocks plus one per wait.
// Backpressure: WAIT_L low in T2/TW holds the cycle in TW; MRD_start is ignored mid-cycle.
module mrd_fsm
    import z80_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_L,
    input  logic MRD_start,
    input  logic WAIT_L,
    output logic MRD_MREQ_L,
    output logic MRD_RD_L
);

    bus_state_e state;
    bus_state_e state_nxt;

    // State register; reset aborts any cycle in progress immediately.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unreachable encodings fall back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = MRD_start ? T1 : IDLE;
            T1:      state_nxt = T2;
            T2:      state_nxt = WAIT_L ? T3 : TW;
            TW:      state_nxt = WAIT_L ? T3 : TW;
            T3:      state_nxt = MRD_start ? T1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode: both strobes asserted for every phase of the cycle.
    always_comb begin
        MRD_MREQ_L = DEASSERT_L;
        MRD_RD_L   = DEASSERT_L;
        case (state)
            T1, T2, TW, T3: begin
                MRD_MREQ_L = ASSERT_L;
                MRD_RD_L   = ASSERT_L;
            end
            default: begin
                MRD_MREQ_L = DEASSERT_L;
                MRD_RD_L   = DEASSERT_L;
            end
        endcase
    end

    // A read strobe without a memory request would select nothing on the bus.
    a_rd_implies_mreq: assert property (@(posedge clk) disable iff (!rst_L)
        (MRD_RD_L == ASSERT_L) |-> (MRD_MREQ_L == ASSERT_L));

    // Both strobes must be released whenever no cycle is in progress.
    a_idle_released: assert property (@(posedge clk) disable iff (!rst_L)
        (state == IDLE) |-> (MRD_MREQ_L == DEASSERT_L && MRD_RD_L == DEASSERT_L));

endmodule

// File: tb/tb_mrd_fsm.sv
module tb_mrd_fsm;

    logic clk;
    logic rst_L;
    logic MRD_start;
    logic WAIT_L;
    logic MRD_MREQ_L;
    logic MRD_RD_L;

    int checks;
    int fails;

    // Model: position within the current read in clocks (0 = no read),
    // and whether the wait phase has ended (final clock of the read).
    int  m_age;
    bit  m_last;

    // Strobe-low run measurement.
    int  run_len;
    int  last_run;

    mrd_fsm dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .MRD_start  (MRD_start),
        .WAIT_L     (WAIT_L),
        .MRD_MREQ_L (MRD_MREQ_L),
        .MRD_RD_L   (MRD_RD_L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string model_name();
        if (m_age == 0)      return "IDLE";
        if (m_last)          return "T3";
        if (m_age == 1)      return "T1";
        if (m_age == 2)      return "T2";
        return "TW";
    endfunction

    // Behavioural model of a read: T1, T2, as many waits as WAIT_L low samples, then T3.
    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            m_age  = 0;
            m_last = 1'b0;
        end else if (m_age == 0) begin
            if (MRD_start) m_age = 1;
        end else if (m_last) begin
            m_last = 1'b0;
            m_age  = MRD_start ? 1 : 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            if (WAIT_L) m_last = 1'b1;
            m_age = m_age + 1;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        string exp_nm;
        logic  exp_l;
        exp_nm = model_name();
        exp_l  = (exp_nm == "IDLE");
        checks++;
        if (dut.state.name() != exp_nm) begin
            fails++;
            $display("FAIL model_state t=%0t: got %s expected %s", $time, dut.state.name(), exp_nm);
        end
        checks++;
        if (MRD_MREQ_L !== exp_l) begin
            fails++;
            $display("FAIL model_mreq t=%0t: got %b expected %b", $time, MRD_MREQ_L, exp_l);
        end
        checks++;
        if (MRD_RD_L !== exp_l) begin
            fails++;
            $display("FAIL model_rd t=%0t: got %b expected %b", $time, MRD_RD_L, exp_l);
        end
        if (MRD_MREQ_L === 1'b0) begin
            run_len++;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic check_name(input string tag, input string exp_nm);
        checks++;
        if (dut.state.name() != exp_nm) begin
            fails++;
            $display("FAIL %s: state %s expected %s", tag, dut.state.name(), exp_nm);
        end
    endtask

    task automatic check_strobes(input string tag, input logic exp_l);
        checks++;
        if (MRD_MREQ_L !== exp_l || MRD_RD_L !== exp_l) begin
            fails++;
            $display("FAIL %s: mreq=%b rd=%b expected both %b", tag, MRD_MREQ_L, MRD_RD_L, exp_l);
        end
    endtask

    task automatic check_run(input string tag, input int exp_len);
        checks++;
        if (last_run != exp_len) begin
            fails++;
            $display("FAIL %s: strobe low for %0d cycles expected %0d", tag, last_run, exp_len);
        end
    endtask

    // Advance to the next check point: just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        string pat [3];
        pat[0] = "T1"; pat[1] = "T2"; pat[2] = "T3";
        checks = 0; fails = 0;
        run_len = 0; last_run = 0;
        m_age = 0; m_last = 1'b0;

        // Reset held with MRD_start high: stays idle throughout.
        rst_L = 1'b0; MRD_start = 1'b1; WAIT_L = 1'b1;
        #1;
        check_name("reset_imm_state", "IDLE");
        check_strobes("reset_imm_strobes", 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_name("reset_state", "IDLE");
            check_strobes("reset_strobes", 1'b1);
        end
        rst_L = 1'b1; MRD_start = 1'b0;
        tick();
        check_name("post_reset_idle", "IDLE");

        // Single zero-wait read from a one-edge MRD_start pulse.
        MRD_start = 1'b1;
        tick(); check_name("single_t1", "T1"); check_strobes("single_t1_strb", 1'b0);
        MRD_start = 1'b0;
        tick(); check_name("single_t2", "T2");
        tick(); check_name("single_t3", "T3");
        tick(); check_name("single_idle", "IDLE"); check_strobes("single_idle_strb", 1'b1);
        check_run("single_len", 3);

        // Back-to-back reads with MRD_start held; drop it in the final T3.
        MRD_start = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            check_name("b2b_state", pat[i % 3]);
            check_strobes("b2b_strobes", 1'b0);
        end
        MRD_start = 1'b0;
        tick(); check_name("b2b_end_idle", "IDLE");
        check_run("b2b_len", 21);

        // Two wait states, with a simultaneous MRD_start in T2 that must be ignored.
        MRD_start = 1'b1;
        tick(); check_name("wait_t1", "T1");
        MRD_start = 1'b0; WAIT_L = 1'b0;
        tick(); check_name("wait_t2", "T2");
        MRD_start = 1'b1;
        tick(); check_name("wait_tw1", "TW");
        MRD_start = 1'b0;
        tick(); check_name("wait_tw2", "TW");
        WAIT_L = 1'b1;
        tick(); check_name("wait_t3", "T3");
        tick(); check_name("wait_idle", "IDLE");
        check_run("wait_len", 5);

        // Asynchronous reset while in TW, then a fresh read after release.
        MRD_start = 1'b1;
        tick(); check_name("arst_t1", "T1");
        MRD_start = 1'b0; WAIT_L = 1'b0;
        tick(); check_name("arst_t2", "T2");
        tick(); check_name("arst_tw", "TW");
        #2 rst_L = 1'b0;
        #1;
        check_name("arst_imm_state", "IDLE");
        check_strobes("arst_imm_strobes", 1'b1);
        tick(); check_name("arst_held", "IDLE");
        rst_L = 1'b1; WAIT_L = 1'b1; MRD_start = 1'b1;
        tick(); check_name("arst_fresh_t1", "T1");
        MRD_start = 1'b0;
        tick(); check_name("arst_fresh_t2", "T2");
        tick(); check_name("arst_fresh_t3", "T3");
        tick(); check_name("arst_fresh_idle", "IDLE");
        check_run("arst_fresh_len", 3);

        // Reassert MRD_start only in T3: next read follows with no idle gap.
        MRD_start = 1'b1;
        tick(); check_name("re_t1", "T1");
        MRD_start = 1'b0;
        tick(); check_name("re_t2", "T2");
        MRD_start = 1'b1;
        tick(); check_name("re_t3", "T3");
        tick(); check_name("re_t1b", "T1"); check_strobes("re_t1b_strb", 1'b0);
        MRD_start = 1'b0;
        tick(); check_name("re_t2b", "T2");
        tick(); check_name("re_t3b", "T3");
        tick(); check_name("re_idle", "IDLE");
        check_run("re_len", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
